arm_position_writer: RTL and testbench

Writer side of the arm-position memory. It accepts X/Y/Z samples from the motion/teach path over a valid/ready handshake, clamps each sample, and packs it into a 30-bit word. Words are stored sequentially into a 256-entry RAM. A registered read port lets the downstream max-position scanner and playback logic read stored entries. A clear command sweeps the RAM to zero so a fresh teach sequence can be recorded.

---
 rtl/arm_pkg.sv | 52 +++++
 rtl/arm_position_ram.sv | 39 +++
 rtl/arm_position_writer.sv | 137 +++++++++++++
 tb/tb_arm_position_writer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_pkg
//  Description : Shared constants, writer state encoding and the
//                saturate/pack helpers for the arm-position memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package arm_pkg;

    localparam int COORD_WIDTH   = 10;
    localparam int DATA_WIDTH    = 3 * COORD_WIDTH;
    localparam int ADDRESS_WIDTH = 8;
    localparam int MEMORY_SIZE   = 2 ** ADDRESS_WIDTH;
    localparam int COORD_MAX     = 1000;

    // Axis positions inside the packed word: {X, Y, Z}
    localparam int X_LSB = 2 * COORD_WIDTH;
    localparam int X_MSB = X_LSB + COORD_WIDTH - 1;
    localparam int Y_LSB = COORD_WIDTH;
    localparam int Y_MSB = Y_LSB + COORD_WIDTH - 1;
    localparam int Z_LSB = 0;
    localparam int Z_MSB = Z_LSB + COORD_WIDTH - 1;

    localparam logic [COORD_WIDTH-1:0]   COORD_LIMIT = COORD_MAX[COORD_WIDTH-1:0];
    localparam logic [ADDRESS_WIDTH:0]   COUNT_FULL  = MEMORY_SIZE[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0]   COUNT_LAST  = COUNT_FULL - 1'b1;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_LAST   = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FULL  = 2'b01,
        ST_CLEAR = 2'b10
    } state_t;

    function automatic logic [COORD_WIDTH-1:0] sat_axis(input logic [COORD_WIDTH-1:0] v);
        return (v > COORD_LIMIT) ? COORD_LIMIT : v;
    endfunction

    function automatic logic any_over(input logic [COORD_WIDTH-1:0] x,
                                      input logic [COORD_WIDTH-1:0] y,
                                      input logic [COORD_WIDTH-1:0] z);
        return (x > COORD_LIMIT) || (y > COORD_LIMIT) || (z > COORD_LIMIT);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] pack_sat(input logic [COORD_WIDTH-1:0] x,
                                                       input logic [COORD_WIDTH-1:0] y,
                                                       input logic [COORD_WIDTH-1:0] z);
        return {sat_axis(x), sat_axis(y), sat_axis(z)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/arm_position_ram.sv
`default_nettype none
// ============================================================================
//  Module      : arm_position_ram
//  Description : DATA_WIDTH x MEMORY_SIZE RAM, one write port, one registered
//                read port. A same-address read/write returns the old word.
//  Revision    : 1.0 - initial release
// ============================================================================
module arm_position_ram
    import arm_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data
);

    logic [DATA_WIDTH-1:0] mem [MEMORY_SIZE];

    // Storage array: contents survive reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; sampling before the write lands gives old-data-on-collision
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/arm_position_writer.sv
`default_nettype none
// ============================================================================
//  Module      : arm_position_writer
//  Description : Accepts X/Y/Z samples, saturates and packs them, stores them
//                sequentially in the position RAM and supports a zeroing sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module arm_position_writer
    import arm_pkg::*;
#(
    parameter bit SKIP_DUPLICATES = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     pos_valid,
    output logic                     pos_ready,
    input  logic [COORD_WIDTH-1:0]   pos_x,
    input  logic [COORD_WIDTH-1:0]   pos_y,
    input  logic [COORD_WIDTH-1:0]   pos_z,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic [ADDRESS_WIDTH:0]   count,
    output logic                     full,
    output logic                     busy,
    output logic                     wr_done,
    output logic                     dup_skipped,
    output logic                     clamped
);

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0]    last_word;

    logic [DATA_WIDTH-1:0]    sample_word;
    logic                     sample_over;
    logic                     transfer;
    logic                     is_dup;
    logic                     do_store;
    logic                     ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0]    ram_wdata;

    assign sample_word = pack_sat(pos_x, pos_y, pos_z);
    assign sample_over = any_over(pos_x, pos_y, pos_z);
    assign pos_ready   = (state == ST_IDLE) && !clear && rst;
    assign transfer    = pos_valid && pos_ready;
    // An empty memory always takes the first sample, even if it equals the reset word
    assign is_dup      = SKIP_DUPLICATES && (count != '0) && (sample_word == last_word);
    assign do_store    = transfer && !is_dup;
    assign full        = (count == COUNT_FULL);
    assign busy        = (state == ST_CLEAR);

    // RAM write mux: the sweep owns the port while clearing; reset blocks all writes
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = wr_ptr;
        ram_wdata = sample_word;
        if (rst) begin
            if (state == ST_CLEAR) begin
                ram_we    = 1'b1;
                ram_addr  = clr_addr;
                ram_wdata = '0;
            end else if (do_store) begin
                ram_we = 1'b1;
            end
        end
    end

    // Writer FSM with pointer, count, last-word tracking and status pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            clr_addr    <= '0;
            count       <= '0;
            last_word   <= '0;
            wr_done     <= 1'b0;
            dup_skipped <= 1'b0;
            clamped     <= 1'b0;
        end else begin
            wr_done     <= 1'b0;
            dup_skipped <= 1'b0;
            clamped     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                    end else if (transfer) begin
                        clamped <= sample_over;
                        if (is_dup) begin
                            dup_skipped <= 1'b1;
                        end else begin
                            wr_ptr    <= wr_ptr + 1'b1;
                            count     <= count + 1'b1;
                            last_word <= sample_word;
                            wr_done   <= 1'b1;
                            if (count == COUNT_LAST) begin
                                state <= ST_FULL;
                            end
                        end
                    end
                end
                ST_FULL: begin
                    if (clear) begin
                        state    <= ST_CLEAR;
                        clr_addr <= '0;
                    end
                end
                ST_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == ADDR_LAST) begin
                        state     <= ST_IDLE;
                        wr_ptr    <= '0;
                        count     <= '0;
                        last_word <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    arm_position_ram u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (ram_we),
        .wr_addr (ram_addr),
        .wr_data (ram_wdata),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_arm_position_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arm_position_writer
//  Description : Self-checking bench for arm_position_writer with a
//                behavioural memory model and randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_position_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        pos_valid = 1'b0;
    logic        pos_ready;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic [9:0]  pos_z = '0;
    logic [7:0]  rd_addr = '0;
    logic [29:0] rd_data;
    logic [8:0]  count;
    logic        full;
    logic        busy;
    logic        wr_done;
    logic        dup_skipped;
    logic        clamped;

    always #5 clk = ~clk;

    arm_position_writer #(.SKIP_DUPLICATES(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .pos_valid   (pos_valid),
        .pos_ready   (pos_ready),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .pos_z       (pos_z),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .count       (count),
        .full        (full),
        .busy        (busy),
        .wr_done     (wr_done),
        .dup_skipped (dup_skipped),
        .clamped     (clamped)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: memory image, entry count, last stored word, sweep position
    int m_mem   [256];
    bit m_known [256];
    int m_count = 0;
    int m_last  = 0;
    int m_sweep = -1;
    int m_rd    = 0;
    bit m_rd_known = 1'b0;
    bit m_wd = 1'b0, m_dup = 1'b0, m_cl = 1'b0;
    bit started = 1'b0;
    int seq = 1;
    int saved200;

    function automatic int sat(input int v);
        return (v > 1000) ? 1000 : v;
    endfunction

    function automatic int model_pack(input int x, input int y, input int z);
        return sat(x) * 1048576 + sat(y) * 1024 + sat(z);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs the DUT sampled
    task automatic model_step();
        int w;
        if (!rst) begin
            m_count = 0; m_last = 0; m_sweep = -1;
            m_wd = 0; m_dup = 0; m_cl = 0;
            m_rd = 0; m_rd_known = 1;
            started = 1;
            return;
        end
        m_rd       = m_mem[rd_addr];
        m_rd_known = m_known[rd_addr];
        m_wd = 0; m_dup = 0; m_cl = 0;
        if (m_sweep >= 0) begin
            m_mem[m_sweep]   = 0;
            m_known[m_sweep] = 1;
            m_sweep++;
            if (m_sweep == 256) begin
                m_sweep = -1; m_count = 0; m_last = 0;
            end
        end else if (clear) begin
            m_sweep = 0;
        end else if (pos_valid && m_count < 256) begin
            w    = model_pack(pos_x, pos_y, pos_z);
            m_cl = (pos_x > 1000) || (pos_y > 1000) || (pos_z > 1000);
            if (m_count > 0 && w == m_last) begin
                m_dup = 1;
            end else begin
                m_mem[m_count % 256]   = w;
                m_known[m_count % 256] = 1;
                m_count++;
                m_last = w;
                m_wd   = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (started) begin
            chk("pos_ready", int'(pos_ready),
                int'((m_sweep < 0) && (m_count < 256) && !clear && rst));
            chk("count", int'(count), m_count);
            chk("full", int'(full), int'(m_count == 256));
            chk("busy", int'(busy), int'(m_sweep >= 0));
            chk("wr_done", int'(wr_done), int'(m_wd));
            chk("dup_skipped", int'(dup_skipped), int'(m_dup));
            chk("clamped", int'(clamped), int'(m_cl));
            if (m_rd_known) chk("rd_data", int'(rd_data), m_rd);
        end
    end

    task automatic send(input int x, input int y, input int z);
        pos_x = 10'(x); pos_y = 10'(y); pos_z = 10'(z);
        pos_valid = 1'b1;
        tick();
        pos_valid = 1'b0;
    endtask

    task automatic read_at(input int a);
        rd_addr = 8'(a);
        tick();
    endtask

    task automatic fill_to_full();
        pos_valid = 1'b1;
        for (int i = 0; i < 600 && m_count < 256; i++) begin
            pos_x = 10'(seq % 1000);
            pos_y = 10'((seq / 1000) % 1000);
            pos_z = 10'd7;
            rd_addr = 8'($urandom_range(0, 255));
            seq++;
            tick();
        end
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), 256);
        chk("fill_ready", int'(pos_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("held_count", int'(count), 256);
        end
        pos_valid = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("reset_count", int'(count), 0);
        chk("reset_ready", int'(pos_ready), 1);
        chk("reset_rd", int'(rd_data), 0);

        // First write and readback
        rd_addr = 8'd0;
        send(100, 200, 300);
        chk("first_wr_done", int'(wr_done), 1);
        chk("first_count", int'(count), 1);
        read_at(0);
        chk("first_rd", int'(rd_data), 32'h0643212C);

        // Saturation
        send(1023, 5, 5);
        chk("clamp_pulse", int'(clamped), 1);
        read_at(1);
        chk("clamp_rd", int'(rd_data), 32'h3E801405);

        // Duplicate suppression
        send(7, 7, 7);
        chk("dup_first_wr", int'(wr_done), 1);
        send(7, 7, 7);
        chk("dup_pulse", int'(dup_skipped), 1);
        chk("dup_count", int'(count), 3);
        chk("dup_ready", int'(pos_ready), 1);

        // Randomized traffic with frequent repeats and over-range axes
        for (int i = 0; i < 150; i++) begin
            pos_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                pos_x = 10'($urandom_range(0, 3) == 0 ? $urandom_range(990, 1023) : $urandom_range(0, 1023));
                pos_y = 10'($urandom_range(0, 1023));
                pos_z = 10'($urandom_range(0, 3) == 0 ? $urandom_range(995, 1023) : $urandom_range(0, 1023));
            end
            rd_addr = 8'($urandom_range(0, 255));
            tick();
        end
        pos_valid = 1'b0;

        // Fill to FULL, then clear with a sample offered in the same cycle
        fill_to_full();
        pos_valid = 1'b1; clear = 1'b1;
        pos_x = 10'd1; pos_y = 10'd2; pos_z = 10'd3;
        tick();
        clear = 1'b0; pos_valid = 1'b0;
        chk("clear_busy", int'(busy), 1);
        chk("clear_no_accept", int'(count), 256);
        repeat (255) tick();
        chk("clear_busy_end", int'(busy), 1);
        tick();
        chk("clear_done_busy", int'(busy), 0);
        chk("clear_done_count", int'(count), 0);
        for (int a = 0; a < 256; a++) begin
            read_at(a);
            chk("clear_rd", int'(rd_data), 0);
        end
        send(11, 22, 33);
        read_at(0);
        chk("post_clear_rd", int'(rd_data), 32'h00B05821);
        chk("post_clear_count", int'(count), 1);

        // Reset in the middle of a sweep
        fill_to_full();
        saved200 = m_mem[200];
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (10) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_count", int'(count), 0);
        read_at(5);
        chk("abort_rd5", int'(rd_data), 0);
        read_at(9);
        chk("abort_rd9", int'(rd_data), 0);
        read_at(200);
        chk("abort_rd200", int'(rd_data), saved200);
        send(1, 2, 3);
        chk("abort_accept", int'(count), 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
